// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the registered channel selector
package mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Channel index width, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit in a one-hot vector; zero when no bit is set
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// rtl/mux_arb_reg_if.sv - producer channels and consumer port of the selector
interface mux_arb_reg_if
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 5
) ();

    localparam int SEL_W = idx_w(N);

    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;

    // Producers and consumer side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Selector side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority or round-robin grant with its own pointer
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N        = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int SEL_W    = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic [31:0]      grant_ext;

    // Scan from the pointer (or from 0 in fixed mode) upward, wrapping modulo N
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        idx       = '0;
        grant_ext = '0;
        base      = (ARB_MODE == ARB_RR) ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            idx = SEL_W'((int'(base) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        grant_ext[N-1:0] = grant;
        grant_idx        = SEL_W'(onehot_to_idx(grant_ext));
    end

    // Pointer moves past the winner only on an actual transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && (ARB_MODE == ARB_RR)) begin
            ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N-channel valid/ready selector with one registered output slot
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 5,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic         clk,
    input  logic         rst,
    mux_arb_reg_if.slave bus
);

    localparam int SEL_W = idx_w(N);

    logic             load;
    logic             transfer;
    logic [N-1:0]     grant;
    logic [N-1:0]     in_ready;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     sel_data;
    logic [W-1:0]     out_data_q;
    logic [SEL_W-1:0] out_sel_q;
    logic             out_valid_q;

    rr_arbiter #(
        .N        (N),
        .ARB_MODE (ARB_MODE),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.in_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Slot accepts when empty or being drained this cycle; nothing accepted during reset
    always_comb begin
        load     = ~out_valid_q | bus.out_ready;
        in_ready = rst ? '0 : (grant & {N{load}});
        transfer = |(bus.in_valid & in_ready);
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*W +: W];
            end
        end
    end

    // Output slot: push replaces, pop alone clears valid but keeps data/sel
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_sel_q   <= grant_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed bench for the fixed and round-robin selector variants
module tb_mux_arb_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] in_data;
    logic [3:0]  in_valid = 4'b0000;
    logic        out_ready = 1'b0;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    mux_arb_reg_if #(.N(4), .W(5)) if_f ();
    mux_arb_reg_if #(.N(4), .W(5)) if_r ();

    assign if_f.in_data   = in_data;
    assign if_f.in_valid  = in_valid;
    assign if_f.out_ready = out_ready;
    assign if_r.in_data   = in_data;
    assign if_r.in_valid  = in_valid;
    assign if_r.out_ready = out_ready;

    mux_arb_reg #(.N(4), .W(5), .ARB_MODE(0)) dut_f (.clk(clk), .rst(rst), .bus(if_f));
    mux_arb_reg #(.N(4), .W(5), .ARB_MODE(1)) dut_r (.clk(clk), .rst(rst), .bus(if_r));

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (if_f.out_valid !== 1'b0) begin failed++; $display("FAIL rst_fix_valid got %0b want 0", if_f.out_valid); end
        tests++; if (if_r.out_valid !== 1'b0) begin failed++; $display("FAIL rst_rr_valid got %0b want 0", if_r.out_valid); end
        tests++; if (if_r.out_data !== 5'h00) begin failed++; $display("FAIL rst_rr_data got %h want 00", if_r.out_data); end
        tests++; if (if_r.out_sel !== 2'd0) begin failed++; $display("FAIL rst_rr_sel got %0d want 0", if_r.out_sel); end
        tests++; if (if_f.in_ready !== 4'b0000) begin failed++; $display("FAIL rst_fix_in_ready got %b want 0000", if_f.in_ready); end
        tests++; if (if_r.in_ready !== 4'b0000) begin failed++; $display("FAIL rst_rr_in_ready got %b want 0000", if_r.in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (if_f.in_ready !== 4'b0001) begin failed++; $display("FAIL rel_fix_in_ready got %b want 0001", if_f.in_ready); end
        tests++; if (if_r.in_ready !== 4'b0001) begin failed++; $display("FAIL rel_rr_in_ready got %b want 0001", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_f.out_sel !== 2'd0 || if_f.out_data !== 5'h1F) begin failed++; $display("FAIL first_fix got sel %0d data %h want sel 0 data 1f", if_f.out_sel, if_f.out_data); end
        tests++; if (if_r.out_sel !== 2'd0 || if_r.out_data !== 5'h1F) begin failed++; $display("FAIL first_rr got sel %0d data %h want sel 0 data 1f", if_r.out_sel, if_r.out_data); end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            tests++;
            if (if_f.out_valid !== 1'b1 || if_f.out_sel !== 2'd0 || if_f.out_data !== 5'h1F) begin
                failed++;
                $display("FAIL fixed cycle %0d got v%0b sel %0d data %h want v1 sel 0 data 1f", c, if_f.out_valid, if_f.out_sel, if_f.out_data);
            end
            tests++;
            if (if_f.in_ready !== 4'b0001) begin failed++; $display("FAIL fixed_in_ready cycle %0d got %b want 0001", c, if_f.in_ready); end
        end
        tests++; if (dut_f.u_arb.ptr !== 2'd0) begin failed++; $display("FAIL fixed_ptr got %0d want 0", dut_f.u_arb.ptr); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [5];
        logic [4:0] exp_data [5];
        exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_data = '{5'h1F, 5'h0A, 5'h15, 5'h00, 5'h1F};
        apply_reset();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests++;
            if (if_r.out_valid !== 1'b1 || if_r.out_sel !== exp_sel[c] || if_r.out_data !== exp_data[c]) begin
                failed++;
                $display("FAIL rr_seq step %0d got v%0b sel %0d data %h want v1 sel %0d data %h", c, if_r.out_valid, if_r.out_sel, if_r.out_data, exp_sel[c], exp_data[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (if_r.out_sel !== 2'd2 || if_r.out_data !== 5'h15) begin failed++; $display("FAIL bp_setup got sel %0d data %h want sel 2 data 15", if_r.out_sel, if_r.out_data); end
        out_ready = 1'b0;
        #1;
        tests++; if (if_r.in_ready !== 4'b0000) begin failed++; $display("FAIL bp_in_ready got %b want 0000", if_r.in_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if (if_r.out_valid !== 1'b1 || if_r.out_sel !== 2'd2 || if_r.out_data !== 5'h15 || if_r.in_ready !== 4'b0000) begin
                failed++;
                $display("FAIL bp_hold cycle %0d got v%0b sel %0d data %h rdy %b want v1 sel 2 data 15 rdy 0000", c, if_r.out_valid, if_r.out_sel, if_r.out_data, if_r.in_ready);
            end
            tests++; if (dut_r.u_arb.ptr !== 2'd3) begin failed++; $display("FAIL bp_ptr cycle %0d got %0d want 3", c, dut_r.u_arb.ptr); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (if_r.in_ready !== 4'b1000) begin failed++; $display("FAIL bp_release_rdy got %b want 1000", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_r.out_sel !== 2'd3 || if_r.out_data !== 5'h00) begin failed++; $display("FAIL bp_release got sel %0d data %h want sel 3 data 00", if_r.out_sel, if_r.out_data); end
    endtask

    task automatic test_sparse_wrap();
        apply_reset();
        in_valid = 4'b0111;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (dut_r.u_arb.ptr !== 2'd3) begin failed++; $display("FAIL wrap_ptr got %0d want 3", dut_r.u_arb.ptr); end
        in_valid = 4'b0011;
        #1;
        tests++; if (if_r.in_ready !== 4'b0001) begin failed++; $display("FAIL wrap_rdy got %b want 0001", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_r.out_sel !== 2'd0 || if_r.out_data !== 5'h1F) begin failed++; $display("FAIL wrap_ch0 got sel %0d data %h want sel 0 data 1f", if_r.out_sel, if_r.out_data); end
        @(posedge clk); #1;
        tests++; if (if_r.out_sel !== 2'd1 || if_r.out_data !== 5'h0A) begin failed++; $display("FAIL wrap_ch1 got sel %0d data %h want sel 1 data 0a", if_r.out_sel, if_r.out_data); end
        in_valid = 4'b0000;
        #1;
        tests++; if (if_r.in_ready !== 4'b0000) begin failed++; $display("FAIL idle_rdy got %b want 0000", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_r.out_valid !== 1'b0 || if_r.out_data !== 5'h0A || if_r.out_sel !== 2'd1) begin failed++; $display("FAIL drain got v%0b data %h sel %0d want v0 data 0a sel 1", if_r.out_valid, if_r.out_data, if_r.out_sel); end
        @(posedge clk); #1;
        tests++; if (if_r.out_valid !== 1'b0 || dut_r.u_arb.ptr !== 2'd2) begin failed++; $display("FAIL idle_hold got v%0b ptr %0d want v0 ptr 2", if_r.out_valid, dut_r.u_arb.ptr); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        tests++; if (if_r.out_valid !== 1'b1 || if_r.out_data !== 5'h0A) begin failed++; $display("FAIL mid_setup got v%0b data %h want v1 data 0a", if_r.out_valid, if_r.out_data); end
        rst      = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        tests++; if (if_r.in_ready !== 4'b0000) begin failed++; $display("FAIL mid_rst_rdy got %b want 0000", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_r.out_valid !== 1'b0 || dut_r.u_arb.ptr !== 2'd0) begin failed++; $display("FAIL mid_rst got v%0b ptr %0d want v0 ptr 0", if_r.out_valid, dut_r.u_arb.ptr); end
        rst = 1'b0;
        #1;
        tests++; if (if_r.in_ready !== 4'b0001) begin failed++; $display("FAIL mid_after_rdy got %b want 0001", if_r.in_ready); end
        @(posedge clk); #1;
        tests++; if (if_r.out_sel !== 2'd0 || if_r.out_data !== 5'h1F) begin failed++; $display("FAIL mid_after got sel %0d data %h want sel 0 data 1f", if_r.out_sel, if_r.out_data); end
    endtask

    initial begin
        in_data = {5'h00, 5'h15, 5'h0A, 5'h1F};
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
